// File: rtl/pll_reset_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reset_seq_pkg: FSM state encodings and elaboration-time helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package pll_reset_seq_pkg;

    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_bit: multi-stage single-bit synchronizer with async active-high clear
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reset_seq: PLL reset / lock supervisor producing the system reset
// Optional: define PLL_RESET_SEQ_STATS_EN to implement relock_count.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] relock_count
);

    localparam int CW = clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CW-1:0] c_PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] c_LOCK_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    logic          lk;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pll_rst_q;
    logic          sys_rst_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (locked),
        .q_o (lk)
    );

    // Shared counter: restarts from zero on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == c_PLL_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_LOCK_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == c_STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d = S_PLL_RST;
                end
            end
        endcase
    end

    // Outputs decoded from the next state so they change with state_q
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= (state_d == S_PLL_RST);
            sys_rst_q <= (state_d != S_RUN);
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign state   = state_q;

`ifdef PLL_RESET_SEQ_STATS_EN
    logic             relock_ev;
    logic [CNT_W-1:0] relock_q;

    assign relock_ev = ((state_q == S_WAIT_LOCK) && !lk && (cnt_q == c_LOCK_LAST)) ||
                       ((state_q == S_RUN) && !lk);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            relock_q <= '0;
        end else if (relock_ev && (relock_q != {CNT_W{1'b1}})) begin
            relock_q <= relock_q + 1'b1;
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule
`default_nettype wire
